// File: rtl/i2s_master_tx_pkg.sv
// i2s_master_tx_pkg
// Constants and decode helpers shared by the I2S transmitter and its clock
// generator. Other I2S blocks (e.g. i2s_rx) use the same slot and divider
// defaults and the same word-select decode, so both live here.
//   I2S_SLOT_BITS  BCLK periods per channel slot (frame = 2 slots)
//   I2S_BCLK_HALF  system clocks per BCLK half-period
//   lrclk_decode() word-select level for a given bit-counter value
package i2s_master_tx_pkg;

  localparam int I2S_SLOT_BITS = 32;
  localparam int I2S_BCLK_HALF = 8;

  // Word select goes high one BCLK before the right-slot MSB and drops one
  // BCLK before the left-slot MSB (Philips I2S one-bit lead).
  function automatic logic lrclk_decode(input int cnt, input int slot_bits);
    return (cnt >= slot_bits - 1) && (cnt <= 2 * slot_bits - 2);
  endfunction

endpackage

// File: rtl/i2s_master_tx_clkgen.sv
// i2s_master_tx_clkgen
// BCLK divider and frame bit counter for an I2S clock master.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous reset, active-high
//   bclk  out  bit clock, first rise BCLK_HALF clks after reset release
//   fall  out  high during the clk whose edge drives bclk 1->0
//   cnt   out  bit position in frame, advanced on each fall edge
module i2s_master_tx_clkgen
  import i2s_master_tx_pkg::*;
#(
  parameter int SLOT_BITS = I2S_SLOT_BITS,
  parameter int BCLK_HALF = I2S_BCLK_HALF,
  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1,
  localparam int CNT_W = $clog2(2 * SLOT_BITS)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             bclk,
  output logic             fall,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(2 * SLOT_BITS - 1);
  // Starting one short of the last position makes the first fall edge
  // land on the frame-load position.
  localparam logic [CNT_W-1:0] CNT_RESET = CNT_W'(2 * SLOT_BITS - 2);

  logic [DIV_W-1:0] div;
  logic             wrap;

  assign wrap = (div == DIV_LAST);
  assign fall = wrap && bclk;

  always_ff @(posedge clk) begin
    if (rst) begin
      div  <= '0;
      bclk <= 1'b0;
      cnt  <= CNT_RESET;
    end else begin
      if (wrap) begin
        div  <= '0;
        bclk <= ~bclk;
      end else begin
        div <= div + 1'b1;
      end
      if (fall) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_master_tx.sv
// i2s_master_tx
// I2S clock-master transmitter (Philips format). Generates BCLK/LRCLK and
// serialises left/right samples MSB first. Samples enter through a
// single-entry valid/ready buffer; when no pair is waiting at frame load the
// previous pair is repeated and underrun pulses.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   left_in      in   left sample (BITSIZE)
//   right_in     in   right sample (BITSIZE)
//   in_valid     in   sample pair offered
//   in_ready     out  buffer empty; pair taken when in_valid && in_ready
//   bclk         out  bit clock
//   lrclk        out  word select, 0 = left, 1 = right
//   sdata        out  serial data, changes on BCLK falling edge
//   frame_start  out  one-clk pulse when a frame is loaded
//   underrun     out  one-clk pulse when a load finds the buffer empty
module i2s_master_tx
  import i2s_master_tx_pkg::*;
#(
  parameter int BITSIZE   = 16,
  parameter int SLOT_BITS = I2S_SLOT_BITS,
  parameter int BCLK_HALF = I2S_BCLK_HALF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BITSIZE-1:0] left_in,
  input  logic [BITSIZE-1:0] right_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               bclk,
  output logic               lrclk,
  output logic               sdata,
  output logic               frame_start,
  output logic               underrun
);

  localparam int CNT_W = $clog2(2 * SLOT_BITS);
  localparam int IDX_W = (BITSIZE > 1) ? $clog2(BITSIZE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_BITS - 1);

  logic               fall;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_new;
  logic               load;
  logic               accept;
  logic               full;
  logic               full_nxt;
  logic [BITSIZE-1:0] buf_l;
  logic [BITSIZE-1:0] buf_r;
  logic [BITSIZE-1:0] sh_l;
  logic [BITSIZE-1:0] sh_r;
  logic [IDX_W-1:0]   l_idx;
  logic [IDX_W-1:0]   r_idx;
  logic               sdata_nxt;

  i2s_master_tx_clkgen #(
    .SLOT_BITS (SLOT_BITS),
    .BCLK_HALF (BCLK_HALF)
  ) u_clkgen (
    .clk  (clk),
    .rst  (rst),
    .bclk (bclk),
    .fall (fall),
    .cnt  (cnt)
  );

  // Outputs are decoded from the position the counter moves to on this edge.
  assign cnt_new = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
  assign load    = fall && (cnt_new == CNT_LAST);
  assign accept  = in_valid && in_ready;

  // A load only drains a full buffer; an accept can only hit an empty one,
  // so a same-clk accept+load leaves the new pair waiting for the next frame.
  always_comb begin
    full_nxt = full;
    if (load && full) full_nxt = 1'b0;
    if (accept)       full_nxt = 1'b1;
  end

  // Index arithmetic is modulo 2**IDX_W; only evaluated inside the slot ranges.
  always_comb begin
    l_idx     = IDX_W'(BITSIZE - 1) - cnt_new[IDX_W-1:0];
    r_idx     = IDX_W'(BITSIZE - 1) - (cnt_new[IDX_W-1:0] - IDX_W'(SLOT_BITS));
    sdata_nxt = 1'b0;
    if (int'(cnt_new) < BITSIZE) begin
      sdata_nxt = sh_l[l_idx];
    end else if ((int'(cnt_new) >= SLOT_BITS) &&
                 (int'(cnt_new) < SLOT_BITS + BITSIZE)) begin
      sdata_nxt = sh_r[r_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full        <= 1'b0;
      in_ready    <= 1'b1;
      buf_l       <= '0;
      buf_r       <= '0;
      sh_l        <= '0;
      sh_r        <= '0;
      lrclk       <= 1'b0;
      sdata       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      full        <= full_nxt;
      in_ready    <= ~full_nxt;
      frame_start <= load;
      underrun    <= load && !full;
      if (accept) begin
        buf_l <= left_in;
        buf_r <= right_in;
      end
      // Empty buffer at load: shift registers keep the last pair.
      if (load && full) begin
        sh_l <= buf_l;
        sh_r <= buf_r;
      end
      if (fall) begin
        lrclk <= lrclk_decode(int'(cnt_new), SLOT_BITS);
        sdata <= sdata_nxt;
      end
    end
  end

endmodule

// File: tb/tb_i2s_master_tx.sv
module tb_i2s_master_tx;

  localparam int B = 16;
  localparam int S = 32;
  localparam int H = 8;
  localparam int FRAME_CLKS = 2 * S * 2 * H;

  logic         clk;
  logic         rst;
  logic [B-1:0] left_in;
  logic [B-1:0] right_in;
  logic         in_valid;
  logic         in_ready;
  logic         bclk;
  logic         lrclk;
  logic         sdata;
  logic         frame_start;
  logic         underrun;

  i2s_master_tx #(.BITSIZE(B), .SLOT_BITS(S), .BCLK_HALF(H)) dut (
    .clk         (clk),
    .rst         (rst),
    .left_in     (left_in),
    .right_in    (right_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .sdata       (sdata),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: clk edges since reset give BCLK phase and bit position;
  // accepted pairs sit in a queue and are taken whole at each frame load.
  int           n = 0;
  logic [B-1:0] q_l[$];
  logic [B-1:0] q_r[$];
  logic [B-1:0] cur_l, cur_r;
  logic         exp_bclk, exp_lr, exp_sd, exp_fs, exp_ur, exp_rdy;

  always @(posedge clk) begin
    int       k;
    int       c;
    logic     acc;
    logic [3:0] bi;
    if (rst) begin
      n = 0;
      q_l.delete();
      q_r.delete();
      cur_l = '0; cur_r = '0;
      exp_lr = 1'b0; exp_sd = 1'b0; exp_fs = 1'b0; exp_ur = 1'b0;
    end else begin
      acc = in_valid && (q_l.size() == 0);
      n++;
      exp_fs = 1'b0;
      exp_ur = 1'b0;
      if (n % (2 * H) == 0) begin
        k = n / (2 * H);
        c = (2 * S - 2 + k) % (2 * S);
        if (c == 2 * S - 1) begin
          exp_fs = 1'b1;
          if (q_l.size() > 0) begin
            cur_l = q_l.pop_front();
            cur_r = q_r.pop_front();
          end else begin
            exp_ur = 1'b1;
          end
        end
        exp_lr = (c >= S - 1) && (c <= 2 * S - 2);
        exp_sd = 1'b0;
        if (c < B) begin
          bi = 4'(B - 1 - c);
          exp_sd = cur_l[bi];
        end else if (c >= S && c < S + B) begin
          bi = 4'(B - 1 - (c - S));
          exp_sd = cur_r[bi];
        end
      end
      if (acc) begin
        q_l.push_back(left_in);
        q_r.push_back(right_in);
      end
    end
    exp_bclk = ((n / H) % 2) == 1;
    exp_rdy  = (q_l.size() == 0);
    #1;
    chk1("bclk", bclk, exp_bclk);
    chk1("lrclk", lrclk, exp_lr);
    chk1("sdata", sdata, exp_sd);
    chk1("frame_start", frame_start, exp_fs);
    chk1("underrun", underrun, exp_ur);
    chk1("in_ready", in_ready, exp_rdy);
  end

  logic counting = 1'b0;
  int   ur_cnt = 0;
  always @(negedge clk) if (counting && underrun) ur_cnt++;

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_phase(input int ph, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      @(negedge clk);
      if (n % FRAME_CLKS == ph) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    bit ok;
    int rdy_cnt;
    rst = 1'b1; in_valid = 1'b0; left_in = '0; right_in = '0;

    // Reset then idle: zeros and one underrun per frame.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (FRAME_CLKS + 76) @(negedge clk);

    // Known pair accepted before the first load.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; left_in = 16'hA55A; right_in = 16'h8001;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2 * FRAME_CLKS) @(negedge clk);

    // Streaming 8 pairs, each offered as soon as in_ready is high.
    wait_phase(100, ok);
    chk1("stream_sync", ok, 1'b1);
    ur_cnt = 0;
    counting = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_ready(ok);
      chk1("stream_ready", ok, 1'b1);
      in_valid = 1'b1;
      left_in = B'($urandom); right_in = B'($urandom);
      @(negedge clk);
      in_valid = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      @(negedge clk);
      if (frame_start) begin ok = 1'b1; break; end
    end
    chk1("stream_last_load", ok, 1'b1);
    counting = 1'b0;
    chk32("stream_underruns", ur_cnt, 0);
    repeat (FRAME_CLKS + 50) @(negedge clk);

    // Backpressure: valid held high with new data each clk.
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      @(negedge clk);
      left_in = B'($urandom); right_in = B'($urandom);
      if (n % FRAME_CLKS == 200) begin ok = 1'b1; break; end
    end
    chk1("bp_sync", ok, 1'b1);
    rdy_cnt = 0;
    for (int i = 0; i < 3 * FRAME_CLKS; i++) begin
      @(negedge clk);
      left_in = B'($urandom); right_in = B'($urandom);
      if (in_ready) rdy_cnt++;
    end
    chk32("bp_ready_clks", rdy_cnt, 3);
    in_valid = 1'b0;
    repeat (2 * FRAME_CLKS + 50) @(negedge clk);

    // Accept in the same clk as a load with the buffer empty.
    wait_phase(15, ok);
    chk1("same_sync", ok, 1'b1);
    in_valid = 1'b1;
    left_in = B'($urandom); right_in = B'($urandom);
    @(posedge clk);
    #2;
    chk1("same_underrun", underrun, 1'b1);
    chk1("same_frame_start", frame_start, 1'b1);
    chk1("same_in_ready", in_ready, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2 * FRAME_CLKS + 50) @(negedge clk);

    // Reset for one clk at bit position 40 (right slot).
    wait_phase(16 * 42 + 3, ok);
    chk1("midrst_sync", ok, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk1("midrst_bclk", bclk, 1'b0);
    chk1("midrst_lrclk", lrclk, 1'b0);
    chk1("midrst_sdata", sdata, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (FRAME_CLKS + 76) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_master_tx.md
Name: i2s_master_tx

Overview:
I2S clock-master transmitter, the far end of the link that `i2s_rx` consumes. It generates BCLK and LRCLK from the system oscillator and serialises parallel left/right samples in Philips I2S format. It drives an external DAC or amp and acts as a synthesizable codec-ADC stand-in for loopback against `i2s_rx`. Samples enter through a single-entry valid/ready buffer.

Parameters:
BITSIZE, 16, sample width per channel (two's complement, MSB first)
SLOT_BITS, 32, BCLK periods per channel slot; frame = 2*SLOT_BITS; must be >= BITSIZE
BCLK_HALF, 8, clk cycles per BCLK half-period; must be >= 2 (49.152 MHz / 16 = 3.072 MHz BCLK; 64-bit frame gives 48 kHz)

Ports:
clk  input  1  system clock (OSC, 49.152 MHz)
rst  input  1  synchronous reset, active-high
left_in  input  BITSIZE  left sample
right_in  input  BITSIZE  right sample
in_valid  input  1  sample pair offered
in_ready  output  1  buffer empty; pair accepted when in_valid && in_ready
bclk  output  1  I2S bit clock
lrclk  output  1  word select; 0 = left, 1 = right
sdata  output  1  serial data, changes on BCLK falling edge
frame_start  output  1  one-clk pulse when a new frame is loaded
underrun  output  1  one-clk pulse when a load finds the buffer empty

Behaviour:
- Reset (rst high at a clk edge): div=0, bclk=0, lrclk=0, sdata=0, cnt=2*SLOT_BITS-2, buffer empty, in_ready=1, shift regs L=R=0, frame_start=0, underrun=0. rst mid-frame aborts the frame immediately. No partial data is emitted afterward.
- Divider: div counts 0..BCLK_HALF-1. On wrap, bclk toggles. First rise is BCLK_HALF clks after reset release; first fall is at 2*BCLK_HALF.
- Fall event (the clk where bclk goes 1->0): cnt <= (cnt == 2*SLOT_BITS-1) ? 0 : cnt+1. All of lrclk, sdata, frame_start and underrun update only on fall events, except that frame_start and underrun are single-clk pulses.
- lrclk per new cnt: 0 for cnt == 2S-1 or cnt <= S-2; 1 for S-1 <= cnt <= 2S-2, where S = SLOT_BITS. LRCLK therefore leads slot data by one BCLK, per Philips I2S.
- sdata per new cnt:
  - cnt 0..BITSIZE-1: L[BITSIZE-1-cnt]
  - cnt S..S+BITSIZE-1: R[BITSIZE-1-(cnt-S)]
  - all other cnt: 0
- Load: on the fall event where cnt becomes 2S-1:
  - Buffer full: L,R <= buffer; buffer emptied; frame_start=1.
  - Buffer empty: L,R keep the previous pair (the last frame repeats); frame_start=1 and underrun=1.
- Buffer/handshake:
  - in_ready = !full, registered.
  - An accept sets full on the next clk.
  - Accept and load in the same clk can only happen with the buffer empty. In that case underrun fires and the accepted pair is held for the next frame.
  - in_valid while full is ignored. The source must hold the data.
- First frame after reset: reaches load at the 1st fall event (cnt 2S-2 -> 2S-1). It transmits zeros plus underrun unless a pair was accepted beforehand.
- Widths: all counters are sized with $clog2. There is no arithmetic on sample data.

Decomposition:
- Shared include `i2s_defs.vh`:
  - I2S_SLOT_BITS = 32
  - I2S_BCLK_HALF = 8
  - a macro for the LRCLK-from-cnt decode
  - `i2s_rx` and future I2S blocks also use this include.
- Sub-module `i2s_clkgen`:
  - Ports: clk, rst, bclk, fall pulse, cnt.
  - Contains the divider and bit counter.
  - Is reused for LRCLK generation elsewhere.
- The top holds the buffer, shift registers and output muxing.

Test Plan:
- Reset then idle: bclk period 16 clks, lrclk period 1024 clks, sdata always 0, underrun pulses once per 1024 clks, in_ready=1.
- Accept L=16'hA55A, R=16'h8001 before the first load:
  - Left slot bits 0..15 = 1010010101011010, bits 16..31 = 0.
  - Right slot = 1000000000000001 then zeros.
  - lrclk edges occur one BCLK before each slot MSB.
  - No underrun on that frame.
- Loopback into `i2s_rx`:
  - Stream 8 pairs, each offered when in_ready goes high.
  - `i2s_rx` left_chan reproduces all 8 left values in order.
  - Zero underrun pulses.
- Backpressure:
  - Hold in_valid=1 continuously with changing data.
  - in_ready is high for exactly one clk per frame (after each load).
  - Each accepted pair appears exactly once on sdata.
- Same-cycle accept/load: buffer empty, in_valid rises in the load clk.
  - underrun=1 in that clk.
  - The current frame repeats the old pair.
  - The accepted pair is sent in the following frame.
- Reset mid-right-slot: assert rst for 1 clk at cnt=40.
  - Next clk: bclk=0, lrclk=0, sdata=0.
  - Timing restarts exactly as after power-on reset.
